// File: rtl/rcu_pll_seq_pkg.sv
// Shared types and constants for the RCU PLL bring-up/reconfiguration sequencer.
package rcu_pll_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SW_BYP,
        SETTLE,
        PROG,
        WAIT_LOCK,
        STABLE,
        SW_PLL
    } state_e;

    localparam logic CLKSEL_BYP = 1'b0;
    localparam logic CLKSEL_PLL = 1'b1;

endpackage

// File: rtl/rcu_pll_seq_if.sv
// Config request handshake between a requester (software/boot logic) and the PLL sequencer.
interface rcu_pll_seq_if #(
    parameter int unsigned CFG_WIDTH = 3
);

    logic                 cfg_valid_i;
    logic                 cfg_ready_o;
    logic [CFG_WIDTH-1:0] cfg_i;

    modport master (
        output cfg_valid_i,
        output cfg_i,
        input  cfg_ready_o
    );

    modport slave (
        input  cfg_valid_i,
        input  cfg_i,
        output cfg_ready_o
    );

endinterface

// File: rtl/rcu_lock_sync.sv
// Reset-to-0 multi-flop synchronizer for asynchronous status inputs (DEPTH >= 2).
module rcu_lock_sync #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o
);

    logic [DEPTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], async_i};
        end
    end

    assign sync_o = sync_q[DEPTH-1];

endmodule

// File: rtl/rcu_pll_seq.sv
// PLL bring-up/reconfiguration sequencer: bypass, settle, reprogram, debounced lock, switch back.
// Optional lock-loss monitor enabled by defining RCU_PLL_SEQ_LOSS_MON_EN.
module rcu_pll_seq
    import rcu_pll_seq_pkg::*;
#(
    parameter int unsigned CFG_WIDTH     = 3,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned LOCK_STABLE   = 8,
    parameter int unsigned TIMEOUT       = 4096
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    rcu_pll_seq_if.slave         cfg_if,
    input  logic                 pll_lock_i,
    output logic                 pll_en_o,
    output logic [CFG_WIDTH-1:0] pll_cfg_o,
    output logic                 clk_sel_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    input  logic                 err_clr_i,
    output logic                 loss_o
);

    localparam int unsigned CNT_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned STAB_W = $clog2(LOCK_STABLE + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [STAB_W-1:0]    stab_q, stab_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [CFG_WIDTH-1:0] cfg_q, cfg_d;
    logic [CFG_WIDTH-1:0] pll_cfg_q, pll_cfg_d;
    logic                 pll_en_q, pll_en_d;
    logic                 clk_sel_q, clk_sel_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 loss_q, loss_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 lock_s;
    logic                 loss_trig;
    logic                 timed_out;

    rcu_lock_sync #(
        .DEPTH (2)
    ) u_lock_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (pll_lock_i),
        .sync_o  (lock_s)
    );

`ifdef RCU_PLL_SEQ_LOSS_MON_EN
    logic lock_low_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_low_q <= 1'b0;
        end else begin
            lock_low_q <= ~lock_s;
        end
    end

    // Two consecutive low samples while running on the PLL count as a real loss.
    assign loss_trig = (clk_sel_q == CLKSEL_PLL) && !lock_s && lock_low_q;
`else
    assign loss_trig = 1'b0;
`endif

    assign timed_out = (tmo_q == TMO_W'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stab_d    = stab_q;
        tmo_d     = tmo_q;
        cfg_d     = cfg_q;
        pll_cfg_d = pll_cfg_q;
        pll_en_d  = pll_en_q;
        clk_sel_d = clk_sel_q;
        done_d    = 1'b0;
        err_d     = err_q & ~err_clr_i;
        loss_d    = loss_q;

        unique case (state_q)
            IDLE: begin
                if (loss_trig) begin
                    clk_sel_d = CLKSEL_BYP;
                    loss_d    = 1'b1;
                    cfg_d     = pll_cfg_q;
                    state_d   = SW_BYP;
                end else if (cfg_if.cfg_valid_i && ready_q) begin
                    cfg_d = cfg_if.cfg_i;
                    if ((cfg_if.cfg_i == pll_cfg_q) && (clk_sel_q == CLKSEL_PLL) && !err_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = SW_BYP;
                    end
                end
            end
            SW_BYP: begin
                clk_sel_d = CLKSEL_BYP;
                pll_en_d  = 1'b0;
                cnt_d     = CNT_W'(SETTLE_CYCLES - 1);
                state_d   = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = PROG;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            PROG: begin
                pll_cfg_d = cfg_q;
                pll_en_d  = 1'b1;
                tmo_d     = '0;
                state_d   = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (timed_out) begin
                    err_d     = 1'b1;
                    pll_en_d  = 1'b0;
                    clk_sel_d = CLKSEL_BYP;
                    state_d   = IDLE;
                end else if (lock_s) begin
                    stab_d  = STAB_W'(1);
                    state_d = STABLE;
                end
            end
            STABLE: begin
                // tmo keeps running across debounce restarts so glitches cannot extend the budget
                tmo_d = tmo_q + TMO_W'(1);
                if (timed_out) begin
                    err_d     = 1'b1;
                    pll_en_d  = 1'b0;
                    clk_sel_d = CLKSEL_BYP;
                    state_d   = IDLE;
                end else if (!lock_s) begin
                    stab_d  = '0;
                    state_d = WAIT_LOCK;
                end else if (stab_q == STAB_W'(LOCK_STABLE)) begin
                    state_d = SW_PLL;
                end else begin
                    stab_d = stab_q + STAB_W'(1);
                end
            end
            SW_PLL: begin
                clk_sel_d = CLKSEL_PLL;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            stab_q    <= '0;
            tmo_q     <= '0;
            cfg_q     <= '0;
            pll_cfg_q <= '0;
            pll_en_q  <= 1'b0;
            clk_sel_q <= CLKSEL_BYP;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            loss_q    <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stab_q    <= stab_d;
            tmo_q     <= tmo_d;
            cfg_q     <= cfg_d;
            pll_cfg_q <= pll_cfg_d;
            pll_en_q  <= pll_en_d;
            clk_sel_q <= clk_sel_d;
            done_q    <= done_d;
            err_q     <= err_d;
            loss_q    <= loss_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign cfg_if.cfg_ready_o = ready_q;
    assign pll_en_o           = pll_en_q;
    assign pll_cfg_o          = pll_cfg_q;
    assign clk_sel_o          = clk_sel_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign err_o              = err_q;
    assign loss_o             = loss_q;

endmodule

// File: tb/tb_rcu_pll_seq.sv
// Directed self-checking bench for rcu_pll_seq (SETTLE_CYCLES=4, LOCK_STABLE=3, TIMEOUT=20).
// Cycle c of a scenario is the interval after the c-th clock edge following the request cycle.
module tb_rcu_pll_seq;

`ifdef RCU_PLL_SEQ_LOSS_MON_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_lock;
    logic       pll_en;
    logic [2:0] pll_cfg;
    logic       clk_sel;
    logic       busy;
    logic       done;
    logic       err;
    logic       err_clr;
    logic       loss;

    int n_cmp  = 0;
    int n_fail = 0;

    rcu_pll_seq_if #(.CFG_WIDTH(3)) cfg_if ();

    rcu_pll_seq #(
        .CFG_WIDTH     (3),
        .SETTLE_CYCLES (4),
        .LOCK_STABLE   (3),
        .TIMEOUT       (20)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cfg_if     (cfg_if),
        .pll_lock_i (pll_lock),
        .pll_en_o   (pll_en),
        .pll_cfg_o  (pll_cfg),
        .clk_sel_o  (clk_sel),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .err_clr_i  (err_clr),
        .loss_o     (loss)
    );

    always #5 clk = ~clk;

    // {ready, busy, done, clk_sel, pll_en, err, loss}
    logic [6:0] obs;
    assign obs = {cfg_if.cfg_ready_o, busy, done, clk_sel, pll_en, err, loss};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pll_lock = 1'b0;
        err_clr = 1'b0;
        cfg_if.cfg_valid_i = 1'b0;
        cfg_if.cfg_i = 3'd0;
        repeat (3) tick();
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            if (obs !== 7'b1000000) begin
                $display("FAIL reset_flags c=%0d got %b want %b", c, obs, 7'b1000000);
                n_fail++;
            end
            n_cmp++;
            if (pll_cfg !== 3'd0) begin
                $display("FAIL reset_cfg c=%0d got %0d want 0", c, pll_cfg);
                n_fail++;
            end
            n_cmp++;
            tick();
        end
    endtask

    task automatic test_basic();
        logic [6:0] exp;
        logic [2:0] exp_cfg;
        pll_lock = 1'b1;
        repeat (3) tick();
        cfg_if.cfg_valid_i = 1'b1;
        cfg_if.cfg_i = 3'd5;
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c == 1) cfg_if.cfg_valid_i = 1'b0;
            exp = {c >= 12, c <= 11, c == 12, c >= 12, c >= 7, 1'b0, 1'b0};
            exp_cfg = (c >= 7) ? 3'd5 : 3'd0;
            if (obs !== exp) begin
                $display("FAIL basic_flags c=%0d got %b want %b", c, obs, exp);
                n_fail++;
            end
            n_cmp++;
            if (pll_cfg !== exp_cfg) begin
                $display("FAIL basic_cfg c=%0d got %0d want %0d", c, pll_cfg, exp_cfg);
                n_fail++;
            end
            n_cmp++;
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp;
        logic [2:0] exp_cfg;
        logic       r;
        cfg_if.cfg_valid_i = 1'b1;
        cfg_if.cfg_i = 3'd6;
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (c == 1) cfg_if.cfg_valid_i = 1'b0;
            if (c == 3) begin
                cfg_if.cfg_valid_i = 1'b1;
                cfg_if.cfg_i = 3'd5;
            end
            if (c == 13) cfg_if.cfg_valid_i = 1'b0;
            r = (c == 12) || (c >= 24);
            exp = {r, !r, (c == 12) || (c == 24),
                   (c < 2) || (c == 12) || (c == 13) || (c >= 24),
                   (c < 2) || (c >= 7 && c <= 13) || (c >= 19),
                   1'b0, 1'b0};
            exp_cfg = (c < 7) ? 3'd5 : ((c < 19) ? 3'd6 : 3'd5);
            if (obs !== exp) begin
                $display("FAIL backpressure_flags c=%0d got %b want %b", c, obs, exp);
                n_fail++;
            end
            n_cmp++;
            if (pll_cfg !== exp_cfg) begin
                $display("FAIL backpressure_cfg c=%0d got %0d want %0d", c, pll_cfg, exp_cfg);
                n_fail++;
            end
            n_cmp++;
        end
        // same config while locked on the PLL: done next cycle, nothing else moves
        cfg_if.cfg_valid_i = 1'b1;
        cfg_if.cfg_i = 3'd5;
        for (int c = 1; c <= 2; c++) begin
            tick();
            cfg_if.cfg_valid_i = 1'b0;
            exp = {1'b1, 1'b0, c == 1, 1'b1, 1'b1, 1'b0, 1'b0};
            if (obs !== exp) begin
                $display("FAIL shortcut_flags c=%0d got %b want %b", c, obs, exp);
                n_fail++;
            end
            n_cmp++;
            if (pll_cfg !== 3'd5) begin
                $display("FAIL shortcut_cfg c=%0d got %0d want 5", c, pll_cfg);
                n_fail++;
            end
            n_cmp++;
        end
    endtask

    task automatic test_timeout();
        logic [6:0] exp;
        logic [2:0] exp_cfg;
        pll_lock = 1'b0;
        cfg_if.cfg_valid_i = 1'b1;
        cfg_if.cfg_i = 3'd2;
        for (int c = 1; c <= 28; c++) begin
            tick();
            if (c == 1) cfg_if.cfg_valid_i = 1'b0;
            exp = {c >= 27, c <= 26, 1'b0, c < 2,
                   (c < 2) || (c >= 7 && c <= 26), c >= 27, 1'b0};
            exp_cfg = (c < 7) ? 3'd5 : 3'd2;
            if (obs !== exp) begin
                $display("FAIL timeout_flags c=%0d got %b want %b", c, obs, exp);
                n_fail++;
            end
            n_cmp++;
            if (pll_cfg !== exp_cfg) begin
                $display("FAIL timeout_cfg c=%0d got %0d want %0d", c, pll_cfg, exp_cfg);
                n_fail++;
            end
            n_cmp++;
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        if (obs !== 7'b1000000) begin
            $display("FAIL err_clr got %b want %b", obs, 7'b1000000);
            n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_lock_glitch();
        logic [6:0] exp;
        logic [2:0] exp_cfg;
        // one-cycle drop during debounce: done slips from c=12 to c=18
        cfg_if.cfg_valid_i = 1'b1;
        cfg_if.cfg_i = 3'd7;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 1) cfg_if.cfg_valid_i = 1'b0;
            pll_lock = (c == 8) || (c == 9) || (c >= 11);
            exp = {c >= 18, c <= 17, c == 18, c >= 18, c >= 7, 1'b0, 1'b0};
            exp_cfg = (c < 7) ? 3'd2 : 3'd7;
            if (obs !== exp) begin
                $display("FAIL glitch_flags c=%0d got %b want %b", c, obs, exp);
                n_fail++;
            end
            n_cmp++;
            if (pll_cfg !== exp_cfg) begin
                $display("FAIL glitch_cfg c=%0d got %0d want %0d", c, pll_cfg, exp_cfg);
                n_fail++;
            end
            n_cmp++;
        end
        // late re-lock: debounce would complete exactly at tmo==19, timeout must win, err_clr too
        cfg_if.cfg_valid_i = 1'b1;
        cfg_if.cfg_i = 3'd3;
        pll_lock = 1'b0;
        for (int c = 1; c <= 28; c++) begin
            tick();
            if (c == 1) cfg_if.cfg_valid_i = 1'b0;
            pll_lock = (c == 8) || (c == 9) || (c >= 21);
            err_clr = (c == 26);
            exp = {c >= 27, c <= 26, 1'b0, c < 2,
                   (c < 2) || (c >= 7 && c <= 26), c >= 27, 1'b0};
            exp_cfg = (c < 7) ? 3'd7 : 3'd3;
            if (obs !== exp) begin
                $display("FAIL glitch_tmo_flags c=%0d got %b want %b", c, obs, exp);
                n_fail++;
            end
            n_cmp++;
            if (pll_cfg !== exp_cfg) begin
                $display("FAIL glitch_tmo_cfg c=%0d got %0d want %0d", c, pll_cfg, exp_cfg);
                n_fail++;
            end
            n_cmp++;
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        if (err !== 1'b0) begin
            $display("FAIL glitch_err_clr got %b want 0", err);
            n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_loss_monitor();
        logic [6:0] exp;
        logic       r;
        cfg_if.cfg_valid_i = 1'b1;
        cfg_if.cfg_i = 3'd5;
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c == 1) cfg_if.cfg_valid_i = 1'b0;
            exp = {c >= 12, c <= 11, c == 12, c >= 12, c >= 7, 1'b0, 1'b0};
            if (obs !== exp) begin
                $display("FAIL loss_setup_flags c=%0d got %b want %b", c, obs, exp);
                n_fail++;
            end
            n_cmp++;
        end
        // raw lock low for four cycles while idle on the PLL
        pll_lock = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            pll_lock = (c >= 4);
            if (LOSS_EN) begin
                r = (c < 4) || (c >= 15);
                exp = {r, !r, c == 15, r, (c < 5) || (c >= 10), 1'b0, c >= 4};
            end else begin
                exp = 7'b1001100;
            end
            if (obs !== exp) begin
                $display("FAIL loss_flags c=%0d got %b want %b", c, obs, exp);
                n_fail++;
            end
            n_cmp++;
            if (pll_cfg !== 3'd5) begin
                $display("FAIL loss_cfg c=%0d got %0d want 5", c, pll_cfg);
                n_fail++;
            end
            n_cmp++;
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] exp;
        cfg_if.cfg_valid_i = 1'b1;
        cfg_if.cfg_i = 3'd4;
        pll_lock = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 1) cfg_if.cfg_valid_i = 1'b0;
            exp = {1'b0, 1'b1, 1'b0, c < 2, (c < 2) || (c >= 7), 1'b0, LOSS_EN};
            if (obs !== exp) begin
                $display("FAIL midrst_pre_flags c=%0d got %b want %b", c, obs, exp);
                n_fail++;
            end
            n_cmp++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if (pll_cfg !== 3'd0) begin
            $display("FAIL midrst_cfg got %0d want 0", pll_cfg);
            n_fail++;
        end
        n_cmp++;
        for (int c = 0; c < 12; c++) begin
            if (obs !== 7'b1000000) begin
                $display("FAIL midrst_flags c=%0d got %b want %b", c, obs, 7'b1000000);
                n_fail++;
            end
            n_cmp++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_timeout();
        test_lock_glitch();
        test_loss_monitor();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
